// File: rtl/ram_to_vga_if.sv
// ram_to_vga_if: frame-RAM read port plus VGA pixel/sync bundle.
// master: scan-out engine (drives address, pixel and syncs)
// slave: RAM and writer side (drives read data and frame_done)
interface ram_to_vga_if;
  logic        frame_done;
  logic [18:0] ram_rdaddr;
  logic [7:0]  ram_q;
  logic [7:0]  pixel;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  modport master(input frame_done, ram_q, output ram_rdaddr, pixel, hsync, vsync, de, frame_start);
  modport slave(output frame_done, ram_q, input ram_rdaddr, pixel, hsync, vsync, de, frame_start);
endinterface

// File: rtl/ram_to_vga.sv
// ram_to_vga: scans the frame RAM out as a VGA stream with the image centred on a black border.
// clk: pixel clock; reset: asynchronous active-high
// bus.frame_done in: RAM holds a complete image; bus.ram_q in: RAM data, 1 clk after address
// bus.ram_rdaddr/pixel/hsync/vsync/de/frame_start out: registered, 2 clk behind the counters
module ram_to_vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240
) (
  input logic        clk,
  input logic        reset,
  ram_to_vga_if.master bus
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X0    = (H_ACTIVE - IMG_W) / 2;
  localparam int Y0    = (V_ACTIVE - IMG_H) / 2;
  typedef enum logic {WAIT_FRAME, DISPLAY} state_t;
  state_t      state_q, state_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [18:0] addr_q, addr_d;
  logic        h_end, v_end;
  logic        hs1_q, vs1_q, de1_q, in1_q, dp1_q, fs1_q;
  logic [7:0]  pix_q;
  logic        hs_q, vs_q, de_q, fs_q;
  function automatic logic win(input logic [9:0] h, input logic [9:0] v);
    return h >= 10'(X0) && h < 10'(X0 + IMG_W) && v >= 10'(Y0) && v < 10'(Y0 + IMG_H);
  endfunction
  // The address is loaded from the next counter values so it is on the RAM
  // port during the counters' own cycle; the registered RAM answers one clk
  // later and the pixel register lands two clk behind the counters.
  always_comb begin
    h_end   = h_q == 10'(H_TOT - 1);
    v_end   = v_q == 10'(V_TOT - 1);
    h_d     = h_end ? 10'd0 : h_q + 10'd1;
    v_d     = h_end ? (v_end ? 10'd0 : v_q + 10'd1) : v_q;
    addr_d  = (h_d == 10'd0 && v_d == 10'd0) ? 19'd0 :
              (win(h_d, v_d) && !(h_d == 10'(X0) && v_d == 10'(Y0))) ? addr_q + 19'd1 : addr_q;
    state_d = (h_end && v_end) ? (bus.frame_done ? DISPLAY : WAIT_FRAME) : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= WAIT_FRAME;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      de1_q   <= 1'b0;
      in1_q   <= 1'b0;
      dp1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      pix_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      hs1_q   <= !(h_q >= 10'(H_ACTIVE + H_FP) && h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
      vs1_q   <= !(v_q >= 10'(V_ACTIVE + V_FP) && v_q < 10'(V_ACTIVE + V_FP + V_SYNC));
      de1_q   <= h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
      in1_q   <= win(h_q, v_q);
      dp1_q   <= state_q == DISPLAY;
      fs1_q   <= h_q == 10'd0 && v_q == 10'd0;
      pix_q   <= (dp1_q && in1_q) ? bus.ram_q : 8'd0;
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
      de_q    <= de1_q;
      fs_q    <= fs1_q;
    end
  assign bus.ram_rdaddr  = addr_q;
  assign bus.pixel       = pix_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.de          = de_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_ram_to_vga.sv
// tb_ram_to_vga: checks ram_to_vga on a scaled-down screen against a position-based model.
module tb_ram_to_vga;
  localparam int HA = 80, HF = 6, HS = 10, HB = 4;
  localparam int VA = 40, VF = 3, VS = 2, VB = 5;
  localparam int IW = 32, IH = 24;
  localparam int LINE = HA + HF + HS + HB;
  localparam int LINES = VA + VF + VS + VB;
  localparam int FRAME = LINE * LINES;
  localparam int X0 = (HA - IW) / 2;
  localparam int Y0 = (VA - IH) / 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ram_to_vga_if bus();
  ram_to_vga #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always @(posedge clk) bus.ram_q <= bus.ram_rdaddr[7:0];
  int   n;
  logic dsp [0:15];
  always @(posedge clk or posedge reset)
    if (reset) begin
      n <= 0;
      for (int i = 0; i < 16; i++) dsp[i] <= 1'b0;
    end else begin
      if (n % FRAME == FRAME - 1) dsp[n / FRAME + 1] <= bus.frame_done;
      n <= n + 1;
    end
  function automatic logic [11:0] model(input int k);
    int p, h, v;
    logic in;
    logic [7:0] pix;
    if (k < 2) return {8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    p   = k - 2;
    h   = p % LINE;
    v   = (p / LINE) % LINES;
    in  = h >= X0 && h < X0 + IW && v >= Y0 && v < Y0 + IH;
    pix = (in && dsp[p / FRAME]) ? 8'((v - Y0) * IW + (h - X0)) : 8'h00;
    return {pix, !(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
            h < HA && v < VA, h == 0 && v == 0};
  endfunction
  int tests = 0, fails = 0;
  int fall1 = 0, fall2 = 0, de_cnt = 0, vs_cnt = 0, hs_cnt = 0, nz3 = 0;
  logic epoch0 = 1'b1;
  logic hs_prev = 1'b1;
  logic [7:0] c [0:6];
  logic [11:0] got, exp_v;
  always @(negedge clk) begin
    exp_v = model(n);
    got = {bus.pixel, bus.hsync, bus.vsync, bus.de, bus.frame_start};
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL cycle n=%0d: got pixel=%h hs/vs/de/fs=%b, expected pixel=%h hs/vs/de/fs=%b",
               n, got[11:4], got[3:0], exp_v[11:4], exp_v[3:0]);
    end
    if (epoch0 && !reset && n >= 2) begin
      if (n - 2 < FRAME) begin
        de_cnt += int'(bus.de);
        vs_cnt += int'(!bus.vsync);
        hs_cnt += int'(!bus.hsync);
      end
      if (hs_prev && !bus.hsync) begin
        if (fall1 == 0) fall1 = n;
        else if (fall2 == 0) fall2 = n;
      end
      if ((n - 2) / FRAME == 3 && bus.pixel != 8'h00) nz3++;
      case (n - 2)
        FRAME + Y0 * LINE + X0:                           c[0] = bus.pixel;
        FRAME + Y0 * LINE + X0 + 1:                       c[1] = bus.pixel;
        FRAME + (Y0 + 1) * LINE + X0:                     c[2] = bus.pixel;
        FRAME + (Y0 + IH - 1) * LINE + X0 + IW - 1:       c[3] = bus.pixel;
        FRAME + Y0 * LINE + X0 - 1:                       c[4] = bus.pixel;
        2 * FRAME + (Y0 + IH - 1) * LINE + X0 + IW - 1:   c[5] = bus.pixel;
        (Y0 + IH - 1) * LINE + X0 + IW - 1:               c[6] = bus.pixel;
        default: ;
      endcase
    end
    hs_prev = bus.hsync;
  end
  task automatic chk(input string name, input int g, input int e);
    tests++;
    if (g != e) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, g, e);
    end
  endtask
  task automatic wait_n(input int k);
    while (n < k) @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 7; i++) c[i] = 8'hAA;
    bus.frame_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset hsync", int'(bus.hsync), 1);
    chk("reset de", int'(bus.de), 0);
    chk("reset rdaddr", int'(bus.ram_rdaddr), 0);
    reset = 1'b0;
    wait_n(20 * LINE);
    bus.frame_done = 1'b1;
    wait_n(2 * FRAME + 20 * LINE + 2);
    bus.frame_done = 1'b0;
    wait_n(3 * FRAME + 30 * LINE + 9);
    epoch0 = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async reset de", int'(bus.de), 0);
    chk("async reset pixel", int'(bus.pixel), 0);
    chk("async reset hsync", int'(bus.hsync), 1);
    chk("async reset vsync", int'(bus.vsync), 1);
    chk("async reset rdaddr", int'(bus.ram_rdaddr), 0);
    chk("first hsync fall", fall1, 88);
    chk("hsync period", fall2 - fall1, 100);
    chk("hsync low per frame", hs_cnt, 500);
    chk("vsync low per frame", vs_cnt, 200);
    chk("de high per frame", de_cnt, 3200);
    chk("pixel (X0,Y0)", int'(c[0]), 0);
    chk("pixel (X0+1,Y0)", int'(c[1]), 1);
    chk("pixel (X0,Y0+1)", int'(c[2]), 32);
    chk("pixel last", int'(c[3]), 255);
    chk("pixel (X0-1,Y0)", int'(c[4]), 0);
    chk("last pixel after frame_done drop", int'(c[5]), 255);
    chk("waiting frame last pixel", int'(c[6]), 0);
    chk("nonzero pixels in black frame", nz3, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk) #1 chk("frame_start 1 clk after release", int'(bus.frame_start), 0);
    @(posedge clk) #1 chk("frame_start 2 clk after release", int'(bus.frame_start), 1);
    bus.frame_done = 1'b1;
    wait_n(FRAME + 3500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
